// File: rtl/data_memory_interface.sv
// Purpose : processor data-memory port with a posted write buffer draining into on-chip RAM.
// Latency : RdValid READ_LATENCY+1 cycles after the read is accepted; a forwarded read returns next cycle.
// Backpr. : Stall is combinational: a write stalls on a full buffer, a read stalls until its data returns.
// Option  : define DMI_STORE_FORWARD_EN to forward buffered write data to matching reads.
module data_memory_interface #(
  parameter int ADDR_BITS    = 8,
  parameter int READ_LATENCY = 2,
  parameter int WBUF_DEPTH   = 4
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Req,
  input  logic                        W,
  input  logic [19:0]                 Daddress,
  input  logic [19:0]                 Dout,
  output logic [19:0]                 DataIn,
  output logic                        RdValid,
  output logic                        Stall,
  output logic [$clog2(WBUF_DEPTH):0] BufCount
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0]    LAT_LOAD = 3'(READ_LATENCY - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(WBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD} state_t;

  state_t               state;
  logic [2:0]           lat_cnt;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [ADDR_BITS-1:0] fifo_addr [WBUF_DEPTH];
  logic [19:0]          fifo_dat  [WBUF_DEPTH];
  logic [19:0]          mem       [2**ADDR_BITS];

  logic full;
  logic is_wr;
  logic is_rd;
  logic rd_new;
  logic push;
  logic drain;
  logic hit;
  logic unused_addr;
`ifdef DMI_STORE_FORWARD_EN
  logic [19:0] hit_dat;
`endif

  // Address bits above the RAM index are don't-care.
  assign unused_addr = ^Daddress[19:ADDR_BITS];

  assign full  = (BufCount == DEPTH_C);
  assign is_wr = Req & W;
  assign is_rd = Req & ~W;
  // While RdValid is high the read on the port is the one being retired, not a new one.
  assign rd_new = is_rd & (state == IDLE) & ~RdValid;
  assign push   = Reset & is_wr & ~full;
  // The head drains whenever the RAM port is not reserved for an in-flight read.
  assign drain  = Reset & (BufCount != '0) & (state != RD_WAIT);

  // Stall: a write waits for buffer room, a read waits until its RdValid cycle.
  always_comb begin
    Stall = 1'b0;
    if (Reset) begin
      if (is_wr)      Stall = full;
      else if (is_rd) Stall = (state != IDLE) | ~RdValid;
    end
  end

  // Search valid entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx = head;
    hit = 1'b0;
`ifdef DMI_STORE_FORWARD_EN
    hit_dat = '0;
`endif
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < BufCount) && (fifo_addr[idx] == Daddress[ADDR_BITS-1:0])) begin
        hit = 1'b1;
`ifdef DMI_STORE_FORWARD_EN
        hit_dat = fifo_dat[idx];
`endif
      end
    end
  end

  // Buffer storage: entries are only meaningful below BufCount, so no reset is needed.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_addr[tail] <= Daddress[ADDR_BITS-1:0];
      fifo_dat[tail]  <= Dout;
    end
  end

  // RAM write port fed by the buffer head; contents survive reset.
  always_ff @(posedge Clock) begin
    if (drain) mem[fifo_addr[head]] <= fifo_dat[head];
  end

  // Control FSM, buffer pointers/occupancy and registered read return.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      rd_addr  <= '0;
      head     <= '0;
      tail     <= '0;
      BufCount <= '0;
      DataIn   <= '0;
      RdValid  <= 1'b0;
    end else begin
      RdValid <= 1'b0;
      if (push)  tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      BufCount <= BufCount + CW'(push) - CW'(drain);
      case (state)
        IDLE: begin
          if (rd_new) begin
            rd_addr <= Daddress[ADDR_BITS-1:0];
            if (hit) begin
`ifdef DMI_STORE_FORWARD_EN
              DataIn  <= hit_dat;
              RdValid <= 1'b1;
`else
              state <= RD_HOLD;
`endif
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
        RD_HOLD: begin
          // Wait for the matching write to reach RAM, then read normally.
          if (BufCount == '0) begin
            state   <= RD_WAIT;
            lat_cnt <= LAT_LOAD;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            DataIn  <= mem[rd_addr];
            RdValid <= 1'b1;
            state   <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_interface.sv
// Self-checking bench for data_memory_interface: reference RAM plus a queue of expected read data.
// READ_LATENCY=4 with a 4-deep buffer so writes issued during one read can fill the buffer.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_data_memory_interface;
  localparam int AB = 8;
  localparam int RL = 4;
  localparam int WD = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req;
  logic                 w;
  logic [19:0]          addr;
  logic [19:0]          wdat;
  logic [19:0]          data_in;
  logic                 rd_valid;
  logic                 stall;
  logic [$clog2(WD):0]  buf_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [19:0] ref_mem [2**AB];
  logic [19:0] exp_q [$];

  always #5 clk = ~clk;

  data_memory_interface #(.ADDR_BITS(AB), .READ_LATENCY(RL), .WBUF_DEPTH(WD)) dut (
    .Clock(clk), .Reset(rst_n), .Req(req), .W(w), .Daddress(addr), .Dout(wdat),
    .DataIn(data_in), .RdValid(rd_valid), .Stall(stall), .BufCount(buf_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic wr, input logic [19:0] a, input logic [19:0] d);
    req = r; w = wr; addr = a; wdat = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 20'h00005, 20'h0);
    step();
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: Stall=%b want 0", stall); end
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 20'h0, 20'h0);
    @(negedge clk);
    n_cmp++; if (data_in !== 20'h0) begin n_bad++; $display("FAIL reset_datain: got %h want 00000", data_in); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rdvalid: got %b want 0", rd_valid); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_idle_stall: got %b want 0", stall); end
    n_cmp++; if (buf_count !== 3'd0) begin n_bad++; $display("FAIL reset_bufcount: got %0d want 0", buf_count); end
    step();
  endtask

  task automatic test_write_read();
    logic [19:0] e;
    bit got;
    int nst;
    exp_q.delete();
    drive(1'b1, 1'b1, 20'h00005, 20'hABCDE);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL wr_stall: got %b want 0", stall); end
    ref_mem[8'h05] = 20'hABCDE;
    step();
    drive(1'b0, 1'b0, 20'h0, 20'h0);
    repeat (5) step();
    @(negedge clk);
    n_cmp++; if (buf_count !== 3'd0) begin n_bad++; $display("FAIL wr_drained: BufCount=%0d want 0", buf_count); end
    step();
    drive(1'b1, 1'b0, 20'h00005, 20'h0);
    exp_q.push_back(ref_mem[8'h05]);
    got = 1'b0; nst = 0;
    for (int c = 0; c < RL + 8 && !got; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rd_accept_stall: got %b want 1", stall); end
      end else if (rd_valid === 1'b1) begin
        got = 1'b1;
        e = exp_q.pop_front();
        n_cmp++; if (c != RL + 1) begin n_bad++; $display("FAIL rd_latency: RdValid at %0d want %0d", c, RL + 1); end
        n_cmp++; if (data_in !== e) begin n_bad++; $display("FAIL rd_data: got %h want %h", data_in, e); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rd_done_stall: got %b want 0", stall); end
        n_cmp++; if (nst != RL) begin n_bad++; $display("FAIL rd_stall_cycles: got %0d want %0d", nst, RL); end
      end else if (stall === 1'b1) begin
        nst++;
      end
      step();
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rd_timeout: RdValid seen 0 want 1"); end
    drive(1'b0, 1'b0, 20'h0, 20'h0);
  endtask

  task automatic test_back_to_back();
    logic [19:0] d;
    logic [19:0] e;
    bit got;
    exp_q.delete();
    // Upper address bits set: only the low ADDR_BITS select the word.
    for (int j = 0; j < 5; j++) begin
      d = 20'(32'h31000 + j * 32'h111);
      drive(1'b1, 1'b1, 20'(32'hA0030 + j), d);
      @(negedge clk);
      n_cmp++;
      if (stall !== 1'b0 || rd_valid !== 1'b0) begin
        n_bad++; $display("FAIL b2b_write%0d: Stall=%b RdValid=%b want 0 0", j, stall, rd_valid);
      end
      ref_mem[8'(32'h30 + j)] = d;
      step();
    end
    drive(1'b0, 1'b0, 20'h0, 20'h0);
    @(negedge clk);
    n_cmp++; if (buf_count !== 3'd1) begin n_bad++; $display("FAIL b2b_count: BufCount=%0d want 1", buf_count); end
    step();
    drive(1'b1, 1'b0, 20'h00031, 20'h0);
    exp_q.push_back(ref_mem[8'h31]);
    got = 1'b0;
    for (int c = 0; c < RL + 8 && !got; c++) begin
      @(negedge clk);
      if (c > 0 && rd_valid === 1'b1) begin
        got = 1'b1;
        e = exp_q.pop_front();
        n_cmp++; if (data_in !== e || c != RL + 1) begin
          n_bad++; $display("FAIL b2b_read: data %h at %0d want %h at %0d", data_in, c, e, RL + 1);
        end
      end
      step();
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL b2b_timeout: RdValid seen 0 want 1"); end
    drive(1'b0, 1'b0, 20'h0, 20'h0);
  endtask

  task automatic test_full_during_read();
    logic [19:0] d;
    logic [19:0] e;
    bit got;
    int j;
    exp_q.delete();
    drive(1'b1, 1'b0, 20'h00033, 20'h0);
    exp_q.push_back(ref_mem[8'h33]);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL full_accept_stall: got %b want 1", stall); end
    j = 0;
    for (int c = 1; c <= 12 && j < 5; c++) begin
      step();
      d = 20'(32'h10A00 + j);
      drive(1'b1, 1'b1, 20'(32'h10 + j), d);
      @(negedge clk);
      if (c <= RL) begin
        n_cmp++; if (buf_count !== 3'(c - 1) || stall !== 1'b0) begin
          n_bad++; $display("FAIL nodrain_c%0d: BufCount=%0d Stall=%b want %0d 0", c, buf_count, stall, c - 1);
        end
      end
      if (c == RL + 1) begin
        e = exp_q.pop_front();
        n_cmp++; if (stall !== 1'b1 || buf_count !== 3'd4) begin
          n_bad++; $display("FAIL full_stall: Stall=%b BufCount=%0d want 1 4", stall, buf_count);
        end
        n_cmp++; if (rd_valid !== 1'b1 || data_in !== e) begin
          n_bad++; $display("FAIL full_rd: RdValid=%b data %h want 1 %h", rd_valid, data_in, e);
        end
      end else begin
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL full_spurious_c%0d: RdValid=%b want 0", c, rd_valid); end
      end
      if (c == RL + 2) begin
        n_cmp++; if (stall !== 1'b0 || buf_count !== 3'd3) begin
          n_bad++; $display("FAIL full_after_drain: Stall=%b BufCount=%0d want 0 3", stall, buf_count);
        end
      end
      if (stall === 1'b0) begin
        ref_mem[8'(32'h10 + j)] = d;
        j++;
      end
    end
    n_cmp++; if (j != 5) begin n_bad++; $display("FAIL full_accepted: got %0d writes want 5", j); end
    step();
    drive(1'b0, 1'b0, 20'h0, 20'h0);
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (buf_count === 3'd0) got = 1'b1;
      step();
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL full_drain_timeout: BufCount=%0d want 0", buf_count); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 20'(32'h10 + k), 20'h0);
      exp_q.push_back(ref_mem[8'(32'h10 + k)]);
      got = 1'b0;
      for (int c = 0; c < RL + 8 && !got; c++) begin
        @(negedge clk);
        if (c > 0 && rd_valid === 1'b1) begin
          got = 1'b1;
          e = exp_q.pop_front();
          n_cmp++; if (data_in !== e) begin n_bad++; $display("FAIL full_readback%0d: got %h want %h", k, data_in, e); end
        end
        step();
      end
      n_cmp++; if (!got) begin n_bad++; $display("FAIL full_readback_timeout%0d: RdValid seen 0 want 1", k); end
    end
    drive(1'b0, 1'b0, 20'h0, 20'h0);
  endtask

  task automatic test_raw();
    logic [19:0] e;
    bit got;
    int lat;
    exp_q.delete();
`ifdef DMI_STORE_FORWARD_EN
    lat = 1;
`else
    // One hold cycle while the matching entry drains, then the normal read.
    lat = RL + 2;
`endif
    drive(1'b1, 1'b1, 20'h00020, 20'h11111);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL raw_wr1_stall: got %b want 0", stall); end
    ref_mem[8'h20] = 20'h11111;
    step();
    drive(1'b1, 1'b1, 20'h00020, 20'h22222);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL raw_wr2_stall: got %b want 0", stall); end
    ref_mem[8'h20] = 20'h22222;
    step();
    drive(1'b1, 1'b0, 20'h00020, 20'h0);
    exp_q.push_back(ref_mem[8'h20]);
    got = 1'b0;
    for (int c = 0; c < RL + 10 && !got; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (buf_count !== 3'd1) begin n_bad++; $display("FAIL raw_buffered: BufCount=%0d want 1", buf_count); end
      end
      if (c > 0 && rd_valid === 1'b1) begin
        got = 1'b1;
        e = exp_q.pop_front();
        n_cmp++; if (c != lat) begin n_bad++; $display("FAIL raw_latency: RdValid at %0d want %0d", c, lat); end
        n_cmp++; if (data_in !== e) begin n_bad++; $display("FAIL raw_data: got %h want %h", data_in, e); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL raw_done_stall: got %b want 0", stall); end
      end else if (stall !== 1'b1) begin
        n_cmp++; n_bad++; $display("FAIL raw_stall_c%0d: got %b want 1", c, stall);
      end
      step();
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL raw_timeout: RdValid seen 0 want 1"); end
    drive(1'b0, 1'b0, 20'h0, 20'h0);
    repeat (3) step();
  endtask

  task automatic test_reset_mid_read();
    logic [19:0] e;
    bit got;
    bit seen;
    exp_q.delete();
    drive(1'b1, 1'b1, 20'h00050, 20'h05050);
    ref_mem[8'h50] = 20'h05050;
    step();
    drive(1'b1, 1'b1, 20'h00051, 20'h05151);
    ref_mem[8'h51] = 20'h05151;
    step();
    drive(1'b0, 1'b0, 20'h0, 20'h0);
    repeat (4) step();
    // Read whose completion is pre-empted by reset: nothing is expected from it.
    drive(1'b1, 1'b0, 20'h00031, 20'h0);
    step();
    drive(1'b1, 1'b1, 20'h00050, 20'hBAD50);
    step();
    drive(1'b1, 1'b1, 20'h00051, 20'hBAD51);
    step();
    drive(1'b0, 1'b0, 20'h0, 20'h0);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (buf_count !== 3'd2) begin n_bad++; $display("FAIL mid_buffered: BufCount=%0d want 2", buf_count); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (buf_count !== 3'd0) begin n_bad++; $display("FAIL mid_bufcount: BufCount=%0d want 0", buf_count); end
    seen = 1'b0;
    for (int c = 0; c < RL + 4; c++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL mid_no_rdvalid: RdValid seen 1 want 0"); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 20'(32'h50 + k), 20'h0);
      exp_q.push_back(ref_mem[8'(32'h50 + k)]);
      got = 1'b0;
      for (int c = 0; c < RL + 8 && !got; c++) begin
        @(negedge clk);
        if (c > 0 && rd_valid === 1'b1) begin
          got = 1'b1;
          e = exp_q.pop_front();
          n_cmp++; if (data_in !== e) begin n_bad++; $display("FAIL mid_readback%0d: got %h want %h", k, data_in, e); end
        end
        step();
      end
      n_cmp++; if (!got) begin n_bad++; $display("FAIL mid_readback_timeout%0d: RdValid seen 0 want 1", k); end
    end
    drive(1'b0, 1'b0, 20'h0, 20'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_full_during_read();
    test_raw();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
